// File: rtl/voice_number_scroll_display.sv
// voice_number_scroll_display
//   Records spoken two-digit numbers between START and DONE voice commands,
//   then scrolls through them on a two-digit seven-segment display.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | no session; display blank; waits for START
//   START | recording; NUMBER codes append to the buffer; shows last entry
//   DONE  | playback; shows entries in turn, SCROLL_CYCLES clocks each
//
// Ports
//   clk                   : clock, rising edge
//   reset                 : synchronous active-high reset
//   ID[5:0]               : recognised word code (0 CANCEL, 5 START,
//                           6..45 NUMBER, 46 DONE, 47 MORE)
//   id_valid              : one-cycle strobe qualifying ID
//   Seven_Segment_Display : {tens[6:0], ones[6:0]}, each {g,f,e,d,c,b,a}
//   state[1:0]            : 0 IDLE, 1 START, 2 DONE
//   count                 : number of stored entries
//   overflow              : sticky, set when a number is dropped (buffer full)
module voice_number_scroll_display #(
  parameter int DEPTH         = 4,
  parameter int SCROLL_CYCLES = 100_000_000,
  parameter bit ACTIVE_LOW    = 1'b1,
  parameter bit BLANK_LZ      = 1'b1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [5:0]                   ID,
  input  logic                         id_valid,
  output logic [13:0]                  Seven_Segment_Display,
  output logic [1:0]                   state,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW = $clog2(SCROLL_CYCLES);

  localparam logic [3:0] CODE_DASH  = 4'd10;
  localparam logic [3:0] CODE_BLANK = 4'd11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t          state_q, state_nx;
  logic [CW-1:0]   count_q, count_nx;
  logic            ovf_q, ovf_nx;
  logic [IW-1:0]   ptr_q, ptr_nx;
  logic [TW-1:0]   timer_q, timer_nx;
  logic [13:0]     seg_q, seg_nx;
  logic            wr_en;
  logic [IW-1:0]   wr_idx;
  logic [IW-1:0]   last_idx;
  logic [5:0]      entries [2**IW];

  logic cmd_cancel, cmd_start, cmd_done, cmd_more, cmd_number;

  assign cmd_cancel = id_valid && (ID == 6'd0);
  assign cmd_start  = id_valid && (ID == 6'd5);
  assign cmd_done   = id_valid && (ID == 6'd46);
  assign cmd_more   = id_valid && (ID == 6'd47);
  assign cmd_number = id_valid && (ID >= 6'd6) && (ID <= 6'd45);

  // count never exceeds DEPTH-1 when used as an index, so truncation is exact
  assign wr_idx   = IW'(count_q);
  assign last_idx = IW'(count_q - CW'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      count_q <= '0;
      ovf_q   <= 1'b0;
      ptr_q   <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_nx;
      count_q <= count_nx;
      ovf_q   <= ovf_nx;
      ptr_q   <= ptr_nx;
      timer_q <= timer_nx;
    end
  end

  // Buffer is not reset: entries are only ever read below index count.
  always_ff @(posedge clk) begin
    if (!reset && wr_en) begin
      entries[wr_idx] <= ID;
    end
  end

  always_comb begin
    state_nx = state_q;
    count_nx = count_q;
    ovf_nx   = ovf_q;
    ptr_nx   = ptr_q;
    timer_nx = timer_q;
    wr_en    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_start) begin
          state_nx = S_START;
          count_nx = '0;
          ovf_nx   = 1'b0;
        end
      end

      S_START: begin
        if (cmd_cancel) begin
          state_nx = S_IDLE;
          count_nx = '0;
          ovf_nx   = 1'b0;
        end else if (cmd_start) begin
          count_nx = '0;
          ovf_nx   = 1'b0;
        end else if (cmd_done) begin
          if (count_q != '0) begin
            state_nx = S_DONE;
            ptr_nx   = '0;
            timer_nx = '0;
          end else begin
            state_nx = S_IDLE;
          end
        end else if (cmd_number) begin
          if (count_q < CW'(DEPTH)) begin
            wr_en    = 1'b1;
            count_nx = count_q + CW'(1);
          end else begin
            ovf_nx = 1'b1;
          end
        end
      end

      S_DONE: begin
        if (timer_q == TW'(SCROLL_CYCLES - 1)) begin
          timer_nx = '0;
          if (CW'(ptr_q) + CW'(1) == count_q) ptr_nx = '0;
          else                                ptr_nx = ptr_q + IW'(1);
        end else begin
          timer_nx = timer_q + TW'(1);
        end
        // commands override a coincident scroll step
        if (cmd_more) begin
          state_nx = S_START;
          ptr_nx   = '0;
          timer_nx = '0;
        end else if (cmd_cancel) begin
          state_nx = S_IDLE;
          count_nx = '0;
          ovf_nx   = 1'b0;
          ptr_nx   = '0;
          timer_nx = '0;
        end
      end

      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  function automatic logic [6:0] seg_al(input logic [3:0] code);
    case (code)
      4'd0:    seg_al = 7'h40;
      4'd1:    seg_al = 7'h79;
      4'd2:    seg_al = 7'h24;
      4'd3:    seg_al = 7'h30;
      4'd4:    seg_al = 7'h19;
      4'd5:    seg_al = 7'h12;
      4'd6:    seg_al = 7'h02;
      4'd7:    seg_al = 7'h78;
      4'd8:    seg_al = 7'h00;
      4'd9:    seg_al = 7'h10;
      4'd10:   seg_al = 7'h3F;
      default: seg_al = 7'h7F;
    endcase
  endfunction

  logic [5:0]  show_val;
  logic        use_val;
  logic [3:0]  tens_code, ones_code;
  logic [13:0] seg_raw;

  always_comb begin
    show_val  = '0;
    use_val   = 1'b0;
    tens_code = CODE_BLANK;
    ones_code = CODE_BLANK;

    case (state_q)
      S_START: begin
        if (count_q == '0) begin
          tens_code = CODE_DASH;
          ones_code = CODE_DASH;
        end else begin
          show_val = entries[last_idx];
          use_val  = 1'b1;
        end
      end
      S_DONE: begin
        show_val = entries[ptr_q];
        use_val  = 1'b1;
      end
      default: begin
        tens_code = CODE_BLANK;
        ones_code = CODE_BLANK;
      end
    endcase

    if (use_val) begin
      tens_code = 4'(show_val / 6'd10);
      ones_code = 4'(show_val % 6'd10);
      if (BLANK_LZ && tens_code == 4'd0) tens_code = CODE_BLANK;
    end

    seg_raw = {seg_al(tens_code), seg_al(ones_code)};
    seg_nx  = ACTIVE_LOW ? seg_raw : ~seg_raw;
  end

  always_ff @(posedge clk) begin
    if (reset) seg_q <= ACTIVE_LOW ? 14'h3FFF : 14'h0000;
    else       seg_q <= seg_nx;
  end

  assign Seven_Segment_Display = seg_q;
  assign state                 = state_q;
  assign count                 = count_q;
  assign overflow              = ovf_q;

endmodule

// File: doc/voice_number_scroll_display.md
VOICE_NUMBER_SCROLL_DISPLAY -- requirements
Module: voice_number_scroll_display

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the maximum number of recorded numbers held (1..16).
REQ-002 The block SHALL have parameter SCROLL_CYCLES, default 100_000_000, meaning the clocks each recorded number is shown in DONE (>=2).
REQ-003 The block SHALL have parameter ACTIVE_LOW, default 1, meaning segment polarity (1 = lit segment driven 0; 0 = lit segment driven 1).
REQ-004 The block SHALL have parameter BLANK_LZ, default 1, meaning the tens digit is blanked when its value is 0.
REQ-005 The block SHALL have port clk, input, 1, meaning the single clock; all logic is on the rising edge.
REQ-006 The block SHALL have port reset, input, 1, meaning synchronous active-high reset.
REQ-007 The block SHALL have port ID, input, 6, meaning the recognised word code.
REQ-008 The block SHALL have port id_valid, input, 1, meaning a one-cycle strobe; ID is sampled only when id_valid=1.
REQ-009 The block SHALL have port Seven_Segment_Display, output, 14, meaning [13:7] tens digit and [6:0] ones digit, each ordered {g,f,e,d,c,b,a}.
REQ-010 The block SHALL have port state, output, 2, meaning 0=IDLE, 1=START, 2=DONE.
REQ-011 The block SHALL have port count, output, clog2(DEPTH+1), meaning the number of stored entries.
REQ-012 The block SHALL have port overflow, output, 1, meaning a sticky flag set when a number is discarded because the buffer is full.

Function
REQ-013 The block SHALL treat ID 0 as CANCEL, 5 as START, 46 as DONE, 47 as MORE, 6..45 as NUMBER (value = ID), and all other codes as ignored.
REQ-014 IDLE SHALL go to START on START, clearing count and overflow; all other codes are ignored.
REQ-015 In START, a NUMBER SHALL be stored at index count and count incremented when count<DEPTH; when count==DEPTH the number is discarded, overflow set to 1, and count unchanged.
REQ-016 In START, DONE SHALL go to DONE when count>0 and to IDLE when count==0.
REQ-017 In START, START SHALL restart the session: count=0, overflow=0, state remains START.
REQ-018 In DONE, MORE SHALL go to START, retaining buffer, count and overflow so that new numbers append.
REQ-019 In START or DONE, CANCEL SHALL go to IDLE and clear count and overflow.
REQ-020 In DONE, NUMBER, DONE and START codes SHALL be ignored.
REQ-021 On entry to DONE, the scroll pointer SHALL be set to 0 and the scroll timer to 0.
REQ-022 In DONE, the timer SHALL count 0..SCROLL_CYCLES-1; at terminal count the pointer advances and wraps from count-1 to 0, and with count==1 it stays at 0.
REQ-023 Shown value: IDLE SHALL show blank on both digits; START with count==0 SHALL show dash on both digits; START with count>0 SHALL show entry count-1; DONE SHALL show entry at pointer.
REQ-024 Shown value SHALL be split into tens = value/10 and ones = value%10; tens==0 SHALL be blank when BLANK_LZ=1, otherwise digit 0.
REQ-025 Active-low patterns SHALL be: 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10, dash=7'h3F, blank=7'h7F; ACTIVE_LOW=0 SHALL output the bitwise inverse.
REQ-026 With id_valid sampled at edge k, state, count and buffer SHALL update at edge k; Seven_Segment_Display is registered and SHALL reflect the new contents at edge k+1.
REQ-027 A scroll advance coinciding with an accepted MORE or CANCEL SHALL be overridden by the command.

Reset
REQ-028 While reset=1 at a clock edge, the block SHALL set state=IDLE, count=0, overflow=0, pointer=0, timer=0, and Seven_Segment_Display to blank (7'h7F per digit when ACTIVE_LOW=1).
REQ-029 Reset SHALL take priority over id_valid; buffer contents need not be cleared, because they are unreachable while count=0.
REQ-030 Reset asserted mid-session or mid-scroll SHALL abort to IDLE on the same edge.

Verification
REQ-031 Bench SHALL cover: reset, then START, 13, 35 -> state=1, count=2, display {7'h30,7'h12} ("35").
REQ-032 Bench SHALL cover, with DEPTH=4, SCROLL_CYCLES=4: START, 13, 35, 44, DONE -> display cycles "13","35","44","13" every 4 clocks.
REQ-033 Bench SHALL cover: in DONE, MORE, 30, DONE -> count=4; then START, 6 -> display {7'h7F,7'h02} with BLANK_LZ=1 and {7'h40,7'h02} with BLANK_LZ=0.
REQ-034 Bench SHALL cover, with DEPTH=2: START, 10, 20, 30 -> count=2, overflow=1, display "20"; then START -> overflow=0.
REQ-035 Bench SHALL cover: START, DONE with count 0 -> IDLE and blank; ID 60 or id_valid=0 with ID=5 -> no change.
REQ-036 Bench SHALL cover: reset pulse during DONE scroll -> state=0, count=0, blank next edge; CANCEL concurrent with timer terminal -> IDLE.
